jtag_ahb_ctrl: RTL and testbench
================================

# jtag_ahb_ctrl

JTAG-side sequencer for the AHB access data register: shifts the 38-bit AHB DR between TDI and TDO, decodes each updated command, and drives a single-outstanding request/acknowledge handshake toward the AHB master bridge. It holds the address pointer, the last read data and the sticky status bits. It sits between the TAP controller/instruction decoder and the AHB bridge, entirely in the TCK domain. Any clock-domain crossing is the bridge's responsibility.

## Interface
Parameters:
- DR_WIDTH, 38, AHB DR length (fixed by the DR format below)

Ports:
- TCK  in  1  test clock; all state on posedge
- TRST  in  1  asynchronous, active-low reset
- TDI  in  1  serial data in
- tdo  out  1  serial data out, equal to sr[0]
- ahb_select  in  1  AHB DR instruction active
- dr_capture  in  1  TAP Capture-DR
- dr_shift  in  1  TAP Shift-DR
- dr_update  in  1  TAP Update-DR (one-cycle pulse)
- tlr_reset  in  1  Test-Logic-Reset; synchronous clear
- bus_req  out  1  request to the bridge
- bus_write  out  1  1 = write, 0 = read
- bus_size  out  2  00 byte, 01 half, 10 word
- bus_addr  out  32  transfer address
- bus_wdata  out  32  write data
- bus_ack  in  1  one-cycle completion pulse
- bus_err  in  1  error response, valid with bus_ack
- bus_rdata  in  32  read data, valid with bus_ack

## Operation
- Update DR format: [37:36] op (00 NOP, 01 SET_ADDR, 10 WRITE, 11 READ); [35:34] size; [33:32] reserved; [31:0] payload.
- Capture DR format: [37] busy; [36] bus_error (sticky); [35] overrun (sticky); [34:32] 0; [31:0] last read data.
- Shift: when ahb_select & dr_shift, sr <= {TDI, sr[37:1]}. Data is shifted LSB first.
- Capture: when ahb_select & dr_capture, sr loads the capture word.
- Update: when ahb_select & dr_update, decode sr:
  - NOP: if payload[0]=1, clear both sticky bits.
  - SET_ADDR: addr_ptr <= payload.
  - WRITE: start a write using addr_ptr and payload.
  - READ: start a read using addr_ptr; payload is ignored.
  - A size of 11 on WRITE or READ issues no request and sets bus_error.
- FSM states:
  - IDLE -> REQ on a valid WRITE or READ.
  - REQ -> IDLE on bus_ack.
- busy = (state == REQ).
- A WRITE or READ update while busy is dropped and sets overrun. SET_ADDR and NOP while busy are also dropped and also set overrun.
- On ack:
  - If bus_err=1, set bus_error; addr_ptr and rdata_q are unchanged.
  - Otherwise, for a read, rdata_q <= bus_rdata.
  - Otherwise (read or write), addr_ptr += 1, 2 or 4 per size, modulo 2^32 (0xFFFFFFFC + 4 = 0).
- tlr_reset or TRST clears all state.

## Timing
- Reset values:
  - sr, addr_ptr and rdata_q are 0.
  - Both sticky bits are 0; state is IDLE.
  - tdo = 0, bus_req = 0, bus_write = 0, bus_size = 00, bus_addr = 0, bus_wdata = 0.
- bus_req rises on the first TCK edge after the dr_update cycle.
- bus_write, bus_size, bus_addr and bus_wdata are registered. They are stable while bus_req=1.
- bus_req falls on the edge that samples bus_ack=1. A new request can therefore issue at the earliest on the next update.
- bus_ack while IDLE is ignored.
- Capture during REQ reports busy=1 and the old rdata_q.
- Simultaneous bus_ack and dr_update on WRITE or READ: the ack completes first. The new command is accepted and is not treated as an overrun.
- tlr_reset concurrent with anything: the clear wins. A mid-transfer clear abandons the request; the bridge must tolerate bus_req dropping without an ack.
- TRST asserted mid-transfer: asynchronous return to reset values.

## Structure
- Shared package jtag_ahb_pkg holds:
  - DR_WIDTH = 38
  - op_t enum (NOP, SET_ADDR, WRITE, READ)
  - size_t enum
  - state_t enum (IDLE, REQ)
  - bit-position localparams for both DR formats
- One sub-module, ahb_dr_shift: the 38-bit capture/shift register with tdo.
- FSM, decoder and address pointer live in jtag_ahb_ctrl.

## Test plan
- Reset: after TRST low then high, capture reads 38'h0; tdo = 0; bus_req = 0.
- SET_ADDR 0x1000, then WRITE word 0xDEADBEEF: one cycle after update, bus_req=1, addr=0x1000, wdata=0xDEADBEEF, size=10. Ack with err=0; then READ presents addr=0x1004.
- READ with bus_rdata=0xCAFEF00D on ack: the next capture shifts out 0x0CAFEF00D with busy=0. Byte read at 0xFFFFFFFF: pointer wraps to 0.
- WRITE issued, second WRITE updated before ack: the second is dropped, overrun=1. NOP with payload 1 clears it; capture shows 0 in bits [36:35].
- Ack with bus_err=1: bus_error=1, addr_ptr unchanged. WRITE with size=11: no bus_req, bus_error=1.
- tlr_reset while bus_req=1: bus_req is 0 on the next edge, state is IDLE, and a subsequent READ issues normally.

Source files
------------

// File: rtl/jtag_ahb_pkg.sv
// Shared types, widths and DR bit positions for the JTAG-to-AHB access sequencer.
package jtag_ahb_pkg;

    localparam int unsigned DR_WIDTH = 38;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_SET_ADDR = 2'b01,
        OP_WRITE    = 2'b10,
        OP_READ     = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Update-DR layout
    localparam int unsigned UPD_OP_HI   = 37;
    localparam int unsigned UPD_OP_LO   = 36;
    localparam int unsigned UPD_SIZE_HI = 35;
    localparam int unsigned UPD_SIZE_LO = 34;
    localparam int unsigned UPD_RSVD_HI = 33;
    localparam int unsigned UPD_RSVD_LO = 32;
    localparam int unsigned PAYLOAD_HI  = 31;
    localparam int unsigned PAYLOAD_LO  = 0;

    // Capture-DR layout
    localparam int unsigned CAP_BUSY = 37;
    localparam int unsigned CAP_BERR = 36;
    localparam int unsigned CAP_OVR  = 35;

    // Address advance for a completed transfer of the given size.
    function automatic logic [ADDR_W-1:0] size_incr(input size_t sz);
        case (sz)
            SZ_BYTE: size_incr = ADDR_W'(1);
            SZ_HALF: size_incr = ADDR_W'(2);
            SZ_WORD: size_incr = ADDR_W'(4);
            default: size_incr = ADDR_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/ahb_dr_shift.sv
// AHB access data register: parallel capture, LSB-first serial shift, tdo = sr[0].
module ahb_dr_shift
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned WIDTH = DR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             capture,
    input  logic             shift,
    input  logic [WIDTH-1:0] capture_word,
    input  logic             tdi,
    output logic [WIDTH-1:0] sr,
    output logic             tdo
);

    // Capture has priority over shift; a TAP never asserts both together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (capture) begin
            sr <= capture_word;
        end else if (shift) begin
            sr <= {tdi, sr[WIDTH-1:1]};
        end
    end

    assign tdo = sr[0];

endmodule

// File: rtl/jtag_ahb_ctrl.sv
// JTAG-side AHB access sequencer: command decode, address pointer, sticky status
// and a single-outstanding req/ack handshake toward the AHB master bridge.
module jtag_ahb_ctrl
    import jtag_ahb_pkg::*;
#(
    parameter int unsigned DR_WIDTH = jtag_ahb_pkg::DR_WIDTH
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              TDI,
    output logic              tdo,
    input  logic              ahb_select,
    input  logic              dr_capture,
    input  logic              dr_shift,
    input  logic              dr_update,
    input  logic              tlr_reset,
    output logic              bus_req,
    output logic              bus_write,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata
);

    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] cap_word;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_ptr, addr_nxt;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;
    logic                berr_q, berr_nxt;
    logic                ovr_q, ovr_nxt;
    logic                req_nxt, write_nxt;
    logic [1:0]          size_nxt;
    logic [ADDR_W-1:0]   baddr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    logic                upd_c;
    logic                busy_c;
    op_t                 upd_op;
    size_t               upd_size;
    logic [DATA_W-1:0]   upd_payload;
    logic [1:0]          unused_rsvd;

    assign upd_c       = ahb_select & dr_update;
    assign upd_op      = op_t'(sr[UPD_OP_HI:UPD_OP_LO]);
    assign upd_size    = size_t'(sr[UPD_SIZE_HI:UPD_SIZE_LO]);
    assign upd_payload = sr[PAYLOAD_HI:PAYLOAD_LO];
    assign unused_rsvd = sr[UPD_RSVD_HI:UPD_RSVD_LO];

    assign cap_word = {(state == ST_REQ), berr_q, ovr_q, 3'b000, rdata_q};

    // Serial data register
    ahb_dr_shift #(
        .WIDTH (DR_WIDTH)
    ) u_dr (
        .clk          (TCK),
        .rst_n        (TRST),
        .clr          (tlr_reset),
        .capture      (ahb_select & dr_capture),
        .shift        (ahb_select & dr_shift),
        .capture_word (cap_word),
        .tdi          (TDI),
        .sr           (sr),
        .tdo          (tdo)
    );

    // Next-state: a same-cycle ack retires first, then the updated command is decoded
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_ptr;
        rdata_nxt = rdata_q;
        berr_nxt  = berr_q;
        ovr_nxt   = ovr_q;
        req_nxt   = bus_req;
        write_nxt = bus_write;
        size_nxt  = bus_size;
        baddr_nxt = bus_addr;
        wdata_nxt = bus_wdata;
        busy_c    = 1'b0;

        if (state == ST_REQ) begin
            if (bus_ack) begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
                if (bus_err) begin
                    berr_nxt = 1'b1;
                end else begin
                    if (!bus_write) begin
                        rdata_nxt = bus_rdata;
                    end
                    addr_nxt = addr_ptr + size_incr(size_t'(bus_size));
                end
            end else begin
                busy_c = 1'b1;
            end
        end

        if (upd_c) begin
            if (busy_c) begin
                ovr_nxt = 1'b1;
            end else begin
                case (upd_op)
                    OP_NOP: begin
                        if (upd_payload[0]) begin
                            berr_nxt = 1'b0;
                            ovr_nxt  = 1'b0;
                        end
                    end
                    OP_SET_ADDR: begin
                        addr_nxt = upd_payload;
                    end
                    OP_WRITE, OP_READ: begin
                        if (upd_size == SZ_RSVD) begin
                            berr_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_REQ;
                            req_nxt   = 1'b1;
                            write_nxt = (upd_op == OP_WRITE);
                            size_nxt  = upd_size;
                            baddr_nxt = addr_nxt;
                            if (upd_op == OP_WRITE) begin
                                wdata_nxt = upd_payload;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State and registered bus outputs; Test-Logic-Reset clears everything
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state     <= ST_IDLE;
            addr_ptr  <= '0;
            rdata_q   <= '0;
            berr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (tlr_reset) begin
            state     <= ST_IDLE;
            addr_ptr  <= '0;
            rdata_q   <= '0;
            berr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            bus_req   <= 1'b0;
            bus_write <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_nxt;
            addr_ptr  <= addr_nxt;
            rdata_q   <= rdata_nxt;
            berr_q    <= berr_nxt;
            ovr_q     <= ovr_nxt;
            bus_req   <= req_nxt;
            bus_write <= write_nxt;
            bus_size  <= size_nxt;
            bus_addr  <= baddr_nxt;
            bus_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_jtag_ahb_ctrl.sv
// Directed, table-driven bench for jtag_ahb_ctrl.
module tb_jtag_ahb_ctrl;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        TDI;
    logic        tdo;
    logic        ahb_select;
    logic        dr_capture;
    logic        dr_shift;
    logic        dr_update;
    logic        tlr_reset;
    logic        bus_req;
    logic        bus_write;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] NOP = 2'b00, SETA = 2'b01, WR = 2'b10, RD = 2'b11;

    jtag_ahb_ctrl #(.DR_WIDTH(38)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TDI        (TDI),
        .tdo        (tdo),
        .ahb_select (ahb_select),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .tlr_reset  (tlr_reset),
        .bus_req    (bus_req),
        .bus_write  (bus_write),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .bus_rdata  (bus_rdata)
    );

    always #5 TCK = ~TCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] payload;
        logic [31:0] rdata;
        logic        err;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [37:0] exp_cap;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    function automatic logic [37:0] mk(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] pl);
        return {op, sz, 2'b00, pl};
    endfunction

    // Capture then shift din in; dout collects the captured word from tdo
    task automatic scan_pre(input logic [37:0] din, output logic [37:0] dout);
        dr_capture = 1'b1;
        step();
        dr_capture = 1'b0;
        dr_shift = 1'b1;
        for (int i = 0; i < 38; i++) begin
            TDI = din[i];
            dout[i] = tdo;
            step();
        end
        dr_shift = 1'b0;
        TDI = 1'b0;
    endtask

    task automatic scan(input logic [37:0] din, output logic [37:0] dout);
        scan_pre(din, dout);
        dr_update = 1'b1;
        step();
        dr_update = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd, input logic err);
        bus_ack = 1'b1;
        bus_err = err;
        bus_rdata = rd;
        step();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        bus_rdata = 32'h0;
    endtask

    initial begin
        logic [37:0] dout;

        TRST = 1'b0; TDI = 1'b0; ahb_select = 1'b1; dr_capture = 1'b0;
        dr_shift = 1'b0; dr_update = 1'b0; tlr_reset = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;

        //                op    size   payload       rdata         err   req   addr          capture after
        vecs[0]  = '{SETA, 2'b00, 32'h0000_1000, 32'h0,        1'b0, 1'b0, 32'h0,        38'h00_0000_0000};
        vecs[1]  = '{WR,   2'b10, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1, 32'h0000_1000, 38'h00_0000_0000};
        vecs[2]  = '{RD,   2'b10, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_1004, 38'h00_CAFE_F00D};
        vecs[3]  = '{RD,   2'b01, 32'h0,        32'h0000_BEEF, 1'b0, 1'b1, 32'h0000_1008, 38'h00_0000_BEEF};
        vecs[4]  = '{SETA, 2'b00, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 32'h0,        38'h00_0000_BEEF};
        vecs[5]  = '{RD,   2'b00, 32'h0,        32'h0000_00AB, 1'b0, 1'b1, 32'hFFFF_FFFF, 38'h00_0000_00AB};
        vecs[6]  = '{RD,   2'b10, 32'h0,        32'h0000_0011, 1'b0, 1'b1, 32'h0000_0000, 38'h00_0000_0011};
        vecs[7]  = '{WR,   2'b10, 32'h0000_0055, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 38'h10_0000_0011};
        vecs[8]  = '{RD,   2'b10, 32'h0,        32'h0000_0099, 1'b0, 1'b1, 32'h0000_0004, 38'h10_0000_0099};
        vecs[9]  = '{NOP,  2'b00, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 32'h0,        38'h00_0000_0099};
        vecs[10] = '{WR,   2'b11, 32'h0000_0077, 32'h0,        1'b0, 1'b0, 32'h0,        38'h10_0000_0099};
        vecs[11] = '{NOP,  2'b00, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 32'h0,        38'h00_0000_0099};

        // Reset
        step(); step();
        TRST = 1'b1;
        step();
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_write", 64'(bus_write), 64'd0);
        check("rst_size", 64'(bus_size), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wdata", 64'(bus_wdata), 64'd0);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("rst_capture", 64'(dout), 64'd0);

        // Table-driven command/ack/capture round trips
        for (int i = 0; i < 12; i++) begin
            scan(mk(vecs[i].op, vecs[i].size, vecs[i].payload), dout);
            check($sformatf("v%0d_req", i), 64'(bus_req), 64'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d_addr", i), 64'(bus_addr), 64'(vecs[i].exp_addr));
                check($sformatf("v%0d_size", i), 64'(bus_size), 64'(vecs[i].size));
                check($sformatf("v%0d_write", i), 64'(bus_write), 64'(vecs[i].op == WR));
                if (vecs[i].op == WR) begin
                    check($sformatf("v%0d_wdata", i), 64'(bus_wdata), 64'(vecs[i].payload));
                end
                step();
                check($sformatf("v%0d_req_hold", i), 64'(bus_req), 64'd1);
                ack(vecs[i].rdata, vecs[i].err);
                check($sformatf("v%0d_req_fall", i), 64'(bus_req), 64'd0);
            end
            scan(mk(NOP, 2'b00, 32'h0), dout);
            check($sformatf("v%0d_cap", i), 64'(dout), 64'(vecs[i].exp_cap));
        end

        // Overrun: second WRITE while busy is dropped
        scan(mk(WR, 2'b10, 32'h0000_A5A5), dout);
        check("ovr_req1", 64'(bus_req), 64'd1);
        check("ovr_addr1", 64'(bus_addr), 64'h8);
        scan(mk(WR, 2'b10, 32'h0000_5A5A), dout);
        check("ovr_cap_busy", 64'(dout), 64'h20_0000_0099);
        check("ovr_req_still", 64'(bus_req), 64'd1);
        check("ovr_addr_kept", 64'(bus_addr), 64'h8);
        check("ovr_wdata_kept", 64'(bus_wdata), 64'hA5A5);
        ack(32'h0, 1'b0);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("ovr_cap_set", 64'(dout), 64'h08_0000_0099);
        scan(mk(NOP, 2'b00, 32'h1), dout);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("ovr_sticky_clr", 64'(dout[36:35]), 64'd0);
        check("ovr_cap_clr", 64'(dout), 64'h00_0000_0099);

        // Ack and new READ update in the same cycle: ack first, no overrun
        scan(mk(RD, 2'b10, 32'h0), dout);
        check("sim_req1_addr", 64'(bus_addr), 64'hC);
        scan_pre(mk(RD, 2'b10, 32'h0), dout);
        check("sim_cap_busy", 64'(dout), 64'h20_0000_0099);
        bus_ack = 1'b1; bus_rdata = 32'h77; dr_update = 1'b1;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0; dr_update = 1'b0;
        check("sim_req2", 64'(bus_req), 64'd1);
        check("sim_addr2", 64'(bus_addr), 64'h10);
        check("sim_write2", 64'(bus_write), 64'd0);
        ack(32'h88, 1'b0);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("sim_cap", 64'(dout), 64'h00_0000_0088);

        // Test-Logic-Reset during a transfer
        scan(mk(WR, 2'b10, 32'h1), dout);
        check("tlr_req_before", 64'(bus_req), 64'd1);
        check("tlr_addr_before", 64'(bus_addr), 64'h14);
        tlr_reset = 1'b1;
        step();
        tlr_reset = 1'b0;
        check("tlr_req", 64'(bus_req), 64'd0);
        check("tlr_addr", 64'(bus_addr), 64'd0);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("tlr_cap", 64'(dout), 64'd0);
        scan(mk(RD, 2'b10, 32'h0), dout);
        check("tlr_rd_req", 64'(bus_req), 64'd1);
        check("tlr_rd_addr", 64'(bus_addr), 64'd0);
        ack(32'h5A, 1'b0);
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("tlr_rd_cap", 64'(dout), 64'h5A);

        // Ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFF;
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("idle_ack_cap", 64'(dout), 64'h5A);

        // Asynchronous TRST mid-transfer
        scan(mk(RD, 2'b00, 32'h0), dout);
        check("trst_req_before", 64'(bus_req), 64'd1);
        check("trst_addr_before", 64'(bus_addr), 64'h4);
        #2 TRST = 1'b0;
        #1;
        check("trst_req", 64'(bus_req), 64'd0);
        check("trst_addr", 64'(bus_addr), 64'd0);
        step();
        TRST = 1'b1;
        scan(mk(NOP, 2'b00, 32'h0), dout);
        check("trst_cap", 64'(dout), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
